array_pq_param: RTL

//  Parametrised shift-register (systolic) array priority queue; min-data-first, FIFO among equal keys.

---
 rtl/pq_pkg.sv | 25 ++
 rtl/pq_slot.sv | 59 +++++
 rtl/array_pq_param.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pq_pkg.sv
// Shared types and defaults for the array priority queue.
package pq_pkg;

    // Queue operation codes; values 5..7 are rejected as illegal.
    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_PUSH     = 3'd1,
        OP_POP      = 3'd2,
        OP_DROP_ID  = 3'd3,
        OP_DROP_IDX = 3'd4
    } pq_op_e;

    // Per-slot register source select.
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,  // keep current contents
        SEL_PREV = 2'd1,  // shift in from lower-index neighbour (insert)
        SEL_NEXT = 2'd2,  // shift in from higher-index neighbour (remove)
        SEL_LOAD = 2'd3   // load the pushed entry
    } slot_sel_e;

    localparam int PQ_DEPTH  = 16;
    localparam int PQ_DATA_W = 24;
    localparam int PQ_ID_W   = 24;

endpackage

// File: rtl/pq_slot.sv
// One priority-queue slot: register, "pushed key belongs here or earlier"
// compare, and the hold/shift-in/shift-out/load mux.
module pq_slot
    import pq_pkg::*;
#(
    parameter int DATA_W   = PQ_DATA_W,
    parameter int ID_W     = PQ_ID_W,
    parameter int WRAP_CMP = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  slot_sel_e              sel_i,
    input  logic [DATA_W+ID_W:0]   prev_i,
    input  logic [DATA_W+ID_W:0]   next_i,
    input  logic [DATA_W+ID_W:0]   load_i,
    output logic [DATA_W+ID_W:0]   cell_o,
    output logic                   ins_o
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic              valid;
    } cell_t;

    cell_t cell_q, cell_d, load_c;

    // a < b, either plain unsigned or serial-number (wrap-aware) ordering.
    function automatic logic key_less(input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] diff;
        diff = a - b;
        if (WRAP_CMP != 0) return diff[DATA_W-1];
        else               return a < b;
    endfunction

    assign load_c = cell_t'(load_i);
    assign cell_o = cell_q;
    // Equal keys are not-less, so a pushed entry lands behind its equals.
    assign ins_o  = !cell_q.valid || key_less(load_c.data, cell_q.data);

    // Select the next slot contents.
    always_comb begin
        cell_d = cell_q;
        case (sel_i)
            SEL_PREV: cell_d = cell_t'(prev_i);
            SEL_NEXT: cell_d = cell_t'(next_i);
            SEL_LOAD: cell_d = load_c;
            default:  cell_d = cell_q;
        endcase
    end

    // Slot register, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cell_q <= '0;
        else       cell_q <= cell_d;
    end

endmodule

// File: rtl/array_pq_param.sv
// Systolic shift-register priority queue: min key first, FIFO among equal keys.
// One operation per clock: PUSH, POP, DROP_ID, DROP_IDX.
// Optional feature macro PQ_OVERFLOW_EVICT_EN: PUSH into a full queue evicts
// the largest entry (possibly the pushed one) on evict_* instead of err_o.
module array_pq_param
    import pq_pkg::*;
#(
    parameter int DEPTH    = PQ_DEPTH,
    parameter int DATA_W   = PQ_DATA_W,
    parameter int ID_W     = PQ_ID_W,
    parameter int WRAP_CMP = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         op_valid_i,
    input  logic [2:0]                   op_i,
    input  logic [DATA_W-1:0]            push_data_i,
    input  logic [ID_W-1:0]              push_id_i,
    input  logic [ID_W-1:0]              drop_id_i,
    input  logic [$clog2(DEPTH)-1:0]     drop_idx_i,
    output logic                         op_ready_o,
    output logic                         pop_valid_o,
    output logic [DATA_W-1:0]            pop_data_o,
    output logic [ID_W-1:0]              pop_id_o,
    output logic                         head_valid_o,
    output logic [DATA_W-1:0]            head_data_o,
    output logic [ID_W-1:0]              head_id_o,
    output logic                         drop_hit_o,
    output logic                         drop_miss_o,
    output logic                         err_o,
`ifdef PQ_OVERFLOW_EVICT_EN
    output logic                         evict_valid_o,
    output logic [DATA_W-1:0]            evict_data_o,
    output logic [ID_W-1:0]              evict_id_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int CNT1_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic              valid;
    } cell_t;

    cell_t             cells  [DEPTH];
    cell_t             prev_c [DEPTH];
    cell_t             next_c [DEPTH];
    cell_t             load_c;
    slot_sel_e         sel    [DEPTH];
    logic [DEPTH-1:0]  ins;
    logic [DEPTH-1:0]  ins_prev;
    logic [DEPTH-1:0]  rm_mask;
    logic              push_en;
    logic              seen;
    logic              accept;
    logic              full, empty;

    logic [CNT1_W-1:0] count_q, count_d;
    logic              pop_valid_q, pop_valid_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic [ID_W-1:0]   pop_id_q, pop_id_d;
    logic              drop_hit_q, drop_hit_d;
    logic              drop_miss_q, drop_miss_d;
    logic              err_q, err_d;
`ifdef PQ_OVERFLOW_EVICT_EN
    logic              evict_valid_q, evict_valid_d;
    logic [DATA_W-1:0] evict_data_q, evict_data_d;
    logic [ID_W-1:0]   evict_id_q, evict_id_d;
`endif

    assign op_ready_o = !rst_i;
    assign accept     = op_valid_i && op_ready_o;
    assign full       = (count_q == CNT1_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign load_c     = '{data: push_data_i, id: push_id_i, valid: 1'b1};
    assign ins_prev   = {ins[DEPTH-2:0], 1'b0};

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_first
            assign prev_c[i] = '0;
        end else begin : g_mid_p
            assign prev_c[i] = cells[i-1];
        end
        if (i == DEPTH-1) begin : g_last
            assign next_c[i] = '0;
        end else begin : g_mid_n
            assign next_c[i] = cells[i+1];
        end

        pq_slot #(
            .DATA_W   (DATA_W),
            .ID_W     (ID_W),
            .WRAP_CMP (WRAP_CMP)
        ) u_slot (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .sel_i  (sel[i]),
            .prev_i (prev_c[i]),
            .next_i (next_c[i]),
            .load_i (load_c),
            .cell_o (cells[i]),
            .ins_o  (ins[i])
        );
    end

    // Decode the accepted operation into insert/remove intent, count and pulses.
    always_comb begin
        count_d     = count_q;
        pop_valid_d = 1'b0;
        pop_data_d  = pop_data_q;
        pop_id_d    = pop_id_q;
        drop_hit_d  = 1'b0;
        drop_miss_d = 1'b0;
        err_d       = 1'b0;
        push_en     = 1'b0;
        rm_mask     = '0;
        seen        = 1'b0;
`ifdef PQ_OVERFLOW_EVICT_EN
        evict_valid_d = 1'b0;
        evict_data_d  = evict_data_q;
        evict_id_d    = evict_id_q;
`endif
        if (accept) begin
            case (pq_op_e'(op_i))
                OP_NOP: ;
                OP_PUSH: begin
                    if (!full) begin
                        push_en = 1'b1;
                        count_d = count_q + CNT1_W'(1);
                    end else begin
`ifdef PQ_OVERFLOW_EVICT_EN
                        // Full: the largest of {tail, pushed} leaves via evict_*.
                        evict_valid_d = 1'b1;
                        if (ins[DEPTH-1]) begin
                            push_en      = 1'b1;
                            evict_data_d = cells[DEPTH-1].data;
                            evict_id_d   = cells[DEPTH-1].id;
                        end else begin
                            evict_data_d = push_data_i;
                            evict_id_d   = push_id_i;
                        end
`else
                        err_d = 1'b1;
`endif
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        pop_valid_d = 1'b1;
                        pop_data_d  = cells[0].data;
                        pop_id_d    = cells[0].id;
                        rm_mask     = '1;
                        count_d     = count_q - CNT1_W'(1);
                    end
                end
                OP_DROP_ID: begin
                    // Prefix-OR of matches: first hit and everything above shifts down.
                    for (int i = 0; i < DEPTH; i++) begin
                        seen = seen || (cells[i].valid && (cells[i].id == drop_id_i));
                        rm_mask[i] = seen;
                    end
                    if (seen) begin
                        drop_hit_d = 1'b1;
                        count_d    = count_q - CNT1_W'(1);
                    end else begin
                        drop_miss_d = 1'b1;
                    end
                end
                OP_DROP_IDX: begin
                    if (int'(drop_idx_i) < int'(count_q)) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            rm_mask[i] = (i >= int'(drop_idx_i));
                        end
                        drop_hit_d = 1'b1;
                        count_d    = count_q - CNT1_W'(1);
                    end else begin
                        drop_miss_d = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // Per-slot source: insert point loads, slots behind it shift up; removal shifts down.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = SEL_HOLD;
            if (push_en && ins[i]) begin
                sel[i] = ins_prev[i] ? SEL_PREV : SEL_LOAD;
            end else if (rm_mask[i]) begin
                sel[i] = SEL_NEXT;
            end
        end
    end

    // Count, result registers and one-cycle pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
            pop_id_q    <= '0;
            drop_hit_q  <= 1'b0;
            drop_miss_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
            pop_id_q    <= pop_id_d;
            drop_hit_q  <= drop_hit_d;
            drop_miss_q <= drop_miss_d;
            err_q       <= err_d;
        end
    end

`ifdef PQ_OVERFLOW_EVICT_EN
    // Eviction result register and pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evict_valid_q <= 1'b0;
            evict_data_q  <= '0;
            evict_id_q    <= '0;
        end else begin
            evict_valid_q <= evict_valid_d;
            evict_data_q  <= evict_data_d;
            evict_id_q    <= evict_id_d;
        end
    end

    assign evict_valid_o = evict_valid_q;
    assign evict_data_o  = evict_data_q;
    assign evict_id_o    = evict_id_q;
`endif

    assign pop_valid_o  = pop_valid_q;
    assign pop_data_o   = pop_data_q;
    assign pop_id_o     = pop_id_q;
    assign drop_hit_o   = drop_hit_q;
    assign drop_miss_o  = drop_miss_q;
    assign err_o        = err_q;
    assign head_valid_o = cells[0].valid;
    assign head_data_o  = cells[0].data;
    assign head_id_o    = cells[0].id;
    assign count_o      = count_q;
    assign full_o       = full;
    assign empty_o      = empty;

endmodule
